// File: rtl/text_console_writer.sv
// Text console front end: turns an ASCII/control byte stream into single-beat
// writes to the 80x60 text-mode cell memory, owning the cursor and screen clears.
module text_console_writer #(
    parameter int         COLS    = 80,
    parameter int         ROWS    = 60,
    parameter logic [7:0] BLANK   = 8'h20,
    parameter int         TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    input  logic        clear_req,
    output logic        busy,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        timeout_err,
    output logic        STB,
    output logic        WE,
    output logic [31:0] ADDR,
    output logic [31:0] DAT_O,
    input  logic        ACK
);

    localparam int CELLS = COLS * ROWS;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, ROWCLR, WRITE} state_t;

    state_t        state_q, state_d;
    logic          stb_q;
    logic [TW-1:0] tcnt_q;
    logic [12:0]   idx_q;
    logic          clr_pend_q;
    logic          wr_pend_q;
    logic          wr_char_q;
    logic          row_after_q;
    logic [7:0]    wr_dat_q;

    logic          hs;
    logic          is_print, is_lf, is_cr, is_bs, is_ff;
    logic          bus_tmo, bus_done;
    logic          decide, more, launch;
    logic          start_clear, restart;
    logic [5:0]    y_inc;
    logic [12:0]   row_base;
    logic [12:0]   launch_addr;
    logic [7:0]    launch_dat;

    assign STB = stb_q;
    assign WE  = stb_q;

    assign is_print = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
    assign is_lf    = (ch_data == 8'h0A);
    assign is_cr    = (ch_data == 8'h0D);
    assign is_bs    = (ch_data == 8'h08);
    assign is_ff    = (ch_data == 8'h0C);

    assign hs       = ch_valid && ch_ready;
    assign y_inc    = (cursor_y == 6'(ROWS - 1)) ? 6'd0 : cursor_y + 6'd1;
    assign row_base = 13'(cursor_y) * 13'(COLS);

    // ACK only counts while STB is high, so the stale ACK in the gap cycle is ignored.
    assign bus_tmo  = stb_q && !ACK && (tcnt_q == TW'(TIMEOUT - 1));
    assign bus_done = stb_q && (ACK || bus_tmo);

    // Any non-IDLE cycle with STB low is the gap: either launch the next cell or leave.
    assign decide      = (state_q != IDLE) && !stb_q;
    assign launch      = decide && more;
    assign start_clear = (state_q == IDLE) && (clr_pend_q || (hs && is_ff));
    assign restart     = bus_done && (state_q == CLEAR) && clr_pend_q;

    always_comb begin
        more = 1'b0;
        case (state_q)
            CLEAR:   more = (idx_q < 13'(CELLS));
            ROWCLR:  more = (idx_q < 13'(COLS));
            WRITE:   more = wr_pend_q;
            default: more = 1'b0;
        endcase
    end

    always_comb begin
        launch_addr = row_base + 13'(cursor_x);
        launch_dat  = BLANK;
        case (state_q)
            CLEAR:   launch_addr = idx_q;
            ROWCLR:  launch_addr = row_base + idx_q;
            WRITE:   launch_dat  = wr_dat_q;
            default: launch_dat  = BLANK;
        endcase
    end

    // State register; reset lands in CLEAR so release runs the power-on clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= CLEAR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_clear) begin
                    state_d = CLEAR;
                end else if (hs) begin
                    if (is_print || (is_bs && cursor_x != 7'd0)) state_d = WRITE;
                    else if (is_lf)                              state_d = ROWCLR;
                end
            end
            CLEAR, ROWCLR: begin
                if (decide && !more) state_d = IDLE;
            end
            WRITE: begin
                if (decide && !more) state_d = row_after_q ? ROWCLR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_ready = (state_q == IDLE) && !clr_pend_q;
        busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stb_q  <= 1'b0;
            tcnt_q <= '0;
            ADDR   <= '0;
            DAT_O  <= '0;
        end else if (launch) begin
            stb_q  <= 1'b1;
            tcnt_q <= '0;
            ADDR   <= {19'd0, launch_addr};
            DAT_O  <= {24'd0, launch_dat};
        end else if (bus_done) begin
            stb_q  <= 1'b0;
        end else if (stb_q && !ACK) begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      timeout_err <= 1'b0;
        else if (start_clear || restart) timeout_err <= 1'b0;
        else if (bus_tmo)                timeout_err <= 1'b1;
    end

    // A new clear_req always wins over consumption so back-to-back requests are not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      clr_pend_q <= 1'b0;
        else if (clear_req)              clr_pend_q <= 1'b1;
        else if (start_clear || restart) clr_pend_q <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               idx_q <= '0;
        else if (restart || state_d != state_q)   idx_q <= '0;
        else if (bus_done && state_q != WRITE)    idx_q <= idx_q + 13'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else if (state_q == CLEAR && state_d == IDLE) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else if (hs) begin
            if (is_lf) begin
                cursor_x <= '0;
                cursor_y <= y_inc;
            end else if (is_cr) begin
                cursor_x <= '0;
            end else if (is_bs && cursor_x != 7'd0) begin
                cursor_x <= cursor_x - 7'd1;
            end
        end else if (bus_done && state_q == WRITE && wr_char_q) begin
            // Printable characters advance even when the write was abandoned.
            if (cursor_x == 7'(COLS - 1)) begin
                cursor_x <= '0;
                cursor_y <= y_inc;
            end else begin
                cursor_x <= cursor_x + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_pend_q   <= 1'b0;
            wr_char_q   <= 1'b0;
            row_after_q <= 1'b0;
            wr_dat_q    <= '0;
        end else if (hs && is_print) begin
            wr_pend_q   <= 1'b1;
            wr_char_q   <= 1'b1;
            row_after_q <= 1'b0;
            wr_dat_q    <= ch_data;
        end else if (hs && is_bs && cursor_x != 7'd0) begin
            wr_pend_q   <= 1'b1;
            wr_char_q   <= 1'b0;
            row_after_q <= 1'b0;
            wr_dat_q    <= BLANK;
        end else begin
            if (launch && state_q == WRITE) wr_pend_q <= 1'b0;
            if (bus_done && state_q == WRITE && wr_char_q && cursor_x == 7'(COLS - 1))
                row_after_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: a screen-level model predicts every cell write
// and cursor position; a monitor compares each strobe against the model.
module tb_text_console_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        clear_req;
    logic        busy;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        timeout_err;
    logic        STB;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        ack_en;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  mx, my;
    int  checks   = 0;
    int  failures = 0;
    int  span;

    text_console_writer dut (
        .clk         (clk),
        .reset       (reset),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .ch_ready    (ch_ready),
        .clear_req   (clear_req),
        .busy        (busy),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .timeout_err (timeout_err),
        .STB         (STB),
        .WE          (WE),
        .ADDR        (ADDR),
        .DAT_O       (DAT_O),
        .ACK         (ACK)
    );

    always #5 clk = ~clk;

    // Video card: registered ACK one cycle after STB&WE, can be muted.
    always @(posedge clk or negedge reset) begin
        if (!reset) ACK <= 1'b0;
        else        ACK <= ack_en & STB & WE;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic void expectWrite(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endfunction

    function automatic void modelRow(input int r);
        for (int i = 0; i < COLS; i++) expectWrite(r * COLS + i, 32);
    endfunction

    function automatic void modelClear();
        for (int c = 0; c < CELLS; c++) expectWrite(c, 32);
        mx = 0;
        my = 0;
    endfunction

    function automatic void modelChar(input int c);
        if (c >= 32 && c <= 126) begin
            expectWrite(my * COLS + mx, c);
            if (mx == COLS - 1) begin
                mx = 0;
                my = (my + 1) % ROWS;
                modelRow(my);
            end else begin
                mx++;
            end
        end else if (c == 10) begin
            mx = 0;
            my = (my + 1) % ROWS;
            modelRow(my);
        end else if (c == 13) begin
            mx = 0;
        end else if (c == 8) begin
            if (mx > 0) begin
                mx--;
                expectWrite(my * COLS + mx, 32);
            end
        end else if (c == 12) begin
            modelClear();
        end
    endfunction

    // Every strobe cycle is matched against the oldest outstanding predicted write.
    wr_t cur;
    logic prev_stb = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_stb = 1'b0;
        end else begin
            if (STB) begin
                if (!prev_stb) begin
                    checkOutput("write_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                    end else begin
                        cur.addr = -1;
                        cur.data = -1;
                    end
                end
                checkOutput("wr_we", 32'(WE), 1);
                checkOutput("wr_addr", ADDR, cur.addr);
                checkOutput("wr_data", DAT_O, cur.data);
            end
            prev_stb = STB;
        end
    end

    task automatic applyStimulus(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        ch_valid = 1'b1;
        ch_data  = c;
        while (!ch_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("handshake", 32'(ch_ready), 1);
        @(posedge clk);
        modelChar(int'(c));
        @(negedge clk);
        ch_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget, output int s);
        int first, last, n;
        first = -1;
        last  = -1;
        n     = 0;
        while ((busy || n < 4) && n < budget) begin
            if (STB) begin
                if (first < 0) first = n;
                last = n;
            end
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", 32'(busy), 0);
        checkOutput("pending_writes", 32'(exp_q.size()), 0);
        s = (first < 0) ? 0 : last - first + 1;
    endtask

    task automatic sendChar(input logic [7:0] c, output int s);
        applyStimulus(c);
        waitIdle(1000, s);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset     = 1'b0;
        ch_valid  = 1'b0;
        ch_data   = 8'h00;
        clear_req = 1'b0;
        ack_en    = 1'b1;
        mx        = 0;
        my        = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_stb", 32'(STB), 0);
        checkOutput("rst_addr", ADDR, 0);
        checkOutput("rst_dat", DAT_O, 0);
        checkOutput("rst_cx", 32'(cursor_x), 0);
        checkOutput("rst_cy", 32'(cursor_y), 0);
        checkOutput("rst_terr", 32'(timeout_err), 0);
        checkOutput("rst_ready", 32'(ch_ready), 0);

        // Power-on clear: 4800 cells, 3 cycles each minus the trailing gap.
        modelClear();
        reset = 1'b1;
        waitIdle(20000, span);
        checkOutput("clear_span", span, 14399);
        checkOutput("post_clear_ready", 32'(ch_ready), 1);
        checkOutput("post_clear_busy", 32'(busy), 0);
        checkOutput("post_clear_cx", 32'(cursor_x), 0);
        checkOutput("post_clear_cy", 32'(cursor_y), 0);

        sendChar(8'h41, span);
        checkOutput("a_cx", 32'(cursor_x), 1);
        checkOutput("a_span", span, 2);
        sendChar(8'h0D, span);
        checkOutput("cr_no_stb", span, 0);
        checkOutput("cr_cx", 32'(cursor_x), 0);
        sendChar(8'h01, span);
        checkOutput("ignored_no_stb", span, 0);

        for (int i = 0; i < 3; i++) sendChar(8'h0A, span);
        for (int i = 0; i < 79; i++) sendChar(8'(8'h61 + i % 26), span);
        checkOutput("pre_wrap_cx", 32'(cursor_x), 79);
        checkOutput("pre_wrap_cy", 32'(cursor_y), 3);
        checkOutput("model_wrap_addr", my * COLS + mx, 319);
        sendChar(8'h5A, span);
        checkOutput("wrap_cx", 32'(cursor_x), 0);
        checkOutput("wrap_cy", 32'(cursor_y), 4);

        for (int i = 0; i < 55; i++) sendChar(8'h0A, span);
        checkOutput("bottom_cy", 32'(cursor_y), 59);
        checkOutput("model_row0_first", exp_q.size(), 0);
        sendChar(8'h0A, span);
        checkOutput("lf_wrap_cx", 32'(cursor_x), 0);
        checkOutput("lf_wrap_cy", 32'(cursor_y), 0);

        sendChar(8'h0A, span);
        sendChar(8'h0A, span);
        for (int i = 0; i < 5; i++) sendChar(8'h30, span);
        checkOutput("bs_pre_cx", 32'(cursor_x), 5);
        checkOutput("model_bs_addr", my * COLS + mx - 1, 164);
        sendChar(8'h08, span);
        checkOutput("bs_cx", 32'(cursor_x), 4);
        checkOutput("bs_span", span, 2);
        sendChar(8'h0D, span);
        sendChar(8'h08, span);
        checkOutput("bs0_no_stb", span, 0);
        checkOutput("bs0_cx", 32'(cursor_x), 0);

        // Mute the card: the write must be abandoned after 16 strobe cycles.
        ack_en = 1'b0;
        sendChar(8'h41, span);
        checkOutput("tmo_span", span, 16);
        checkOutput("tmo_err", 32'(timeout_err), 1);
        checkOutput("tmo_cx", 32'(cursor_x), 1);

        ack_en = 1'b1;
        modelClear();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        checkOutput("clrreq_terr", 32'(timeout_err), 0);
        checkOutput("clrreq_busy", 32'(busy), 1);
        waitIdle(20000, span);
        checkOutput("clrreq_span", span, 14399);
        checkOutput("clrreq_cx", 32'(cursor_x), 0);
        checkOutput("clrreq_cy", 32'(cursor_y), 0);

        // Form feed starts a clear; reset lands in the middle of it.
        sendChar(8'h41, span);
        applyStimulus(8'h0C);
        begin
            int n;
            n = 0;
            while (!(STB && ADDR == 32'd2000) && n < 10000) begin
                @(negedge clk);
                n++;
            end
            checkOutput("reached_cell_2000", ADDR, 2000);
        end
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_stb", 32'(STB), 0);
        checkOutput("async_addr", ADDR, 0);
        exp_q.delete();
        modelClear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        waitIdle(20000, span);
        checkOutput("restart_span", span, 14399);
        checkOutput("restart_cx", 32'(cursor_x), 0);
        checkOutput("restart_cy", 32'(cursor_y), 0);
        checkOutput("restart_terr", 32'(timeout_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
